// File: rtl/interrupt_context_stack_pkg.sv
// Shared types for the interrupt context stack: FSM states, default sizing and the
// stack-entry layout (flag field present only when INT_CTX_FLAG_SAVE_EN is defined).
package macpu_int_pkg;

    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_FLAG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        LOAD = 2'd3
    } ctx_state_e;

    // Layout of one saved context at default widths; PC occupies the upper bits.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] pc;
`ifdef INT_CTX_FLAG_SAVE_EN
        logic [DEFAULT_FLAG_W-1:0] flag;
`endif
    } ctx_entry_t;

endpackage

// File: rtl/interrupt_context_stack_if.sv
// Request/response bundle between the interrupt controller side and the context stack.
interface interrupt_context_stack_if #(
    parameter int ADDR_W = 16,
    parameter int FLAG_W = 16,
    parameter int DEPTH  = 8
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic              i_interrupt_enable;
    logic [ADDR_W-1:0] i_interrupt_address;
    logic              i_recovery_enable;
    logic [ADDR_W-1:0] i_pc;
    logic [FLAG_W-1:0] i_flag;
    logic              o_pc_load;
    logic [ADDR_W-1:0] o_pc_address;
    logic              o_flag_load;
    logic [FLAG_W-1:0] o_flag;
    logic              o_busy;
    logic [DEPTH_W-1:0] o_depth;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_interrupt_enable, i_interrupt_address, i_recovery_enable, i_pc, i_flag,
        input  o_pc_load, o_pc_address, o_flag_load, o_flag, o_busy, o_depth,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_interrupt_enable, i_interrupt_address, i_recovery_enable, i_pc, i_flag,
        output o_pc_load, o_pc_address, o_flag_load, o_flag, o_busy, o_depth,
               o_overflow, o_underflow
    );

endinterface

// File: rtl/interrupt_context_stack_ctx_lifo_mem.sv
// Register file backing the context LIFO: synchronous write, registered read.
module ctx_lifo_mem #(
    parameter int ENTRY_W = 16,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [ENTRY_W-1:0]       wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [ENTRY_W-1:0]       rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rdata_q;

    // NOTE: storage has no reset; occupancy in the parent decides which entries are valid.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/interrupt_context_stack.sv
// Interrupt context stack: saves PC (and flags with INT_CTX_FLAG_SAVE_EN) on entry,
// restores them on recovery, through a 4-state FSM around ctx_lifo_mem.
module interrupt_context_stack
    import macpu_int_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int FLAG_W = DEFAULT_FLAG_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       n_rst,
    interrupt_context_stack_if.slave   bus
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int IDX_W   = $clog2(DEPTH);
`ifdef INT_CTX_FLAG_SAVE_EN
    localparam int ENTRY_W = ADDR_W + FLAG_W;
`else
    localparam int ENTRY_W = ADDR_W;
`endif

    ctx_state_e         state_q, state_d;
    logic               int_prev_q, rec_prev_q;
    logic               int_pend_q, int_pend_d, rec_pend_q, rec_pend_d;
    logic [ADDR_W-1:0]  pend_vec_q, pend_vec_d, vec_q, vec_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               is_pop_q, is_pop_d, busy_q, busy_d;
    logic               pc_load_q, pc_load_d, flag_load_q, flag_load_d;
    logic [ADDR_W-1:0]  pc_addr_q, pc_addr_d;
    logic [FLAG_W-1:0]  flag_q, flag_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;

    logic               int_rise, rec_rise, int_req, rec_req;
    logic               mem_we, mem_re;
    logic [ENTRY_W-1:0] mem_wdata, mem_rdata;

    assign int_rise = bus.i_interrupt_enable & ~int_prev_q;
    assign rec_rise = bus.i_recovery_enable & ~rec_prev_q;
    assign int_req  = int_rise | int_pend_q;
    assign rec_req  = rec_rise | rec_pend_q;

`ifdef INT_CTX_FLAG_SAVE_EN
    assign mem_wdata = {bus.i_pc, bus.i_flag};
`else
    assign mem_wdata = bus.i_pc;
    logic [FLAG_W-1:0] unused_flag;
    assign unused_flag = bus.i_flag;
`endif

    // NOTE: every output of this block is given a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        int_pend_d  = int_pend_q;
        rec_pend_d  = rec_pend_q;
        pend_vec_d  = pend_vec_q;
        vec_d       = vec_q;
        depth_d     = depth_q;
        is_pop_d    = is_pop_q;
        pc_addr_d   = pc_addr_q;
        flag_d      = flag_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        pc_load_d   = 1'b0;
        flag_load_d = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        // While busy, each request kind remembers at most one edge; extras are dropped.
        if (state_q != IDLE) begin
            if (int_rise && !int_pend_q) begin
                int_pend_d = 1'b1;
                pend_vec_d = bus.i_interrupt_address;
            end
            if (rec_rise) rec_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (int_req) begin
                    int_pend_d = 1'b0;
                    if (rec_rise) rec_pend_d = 1'b1;
                    if (depth_q < DEPTH_W'(DEPTH)) begin
                        vec_d   = int_pend_q ? pend_vec_q : bus.i_interrupt_address;
                        state_d = PUSH;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (rec_req) begin
                    rec_pend_d = 1'b0;
                    if (depth_q != '0) state_d = POP;
                    else               unf_d   = 1'b1;
                end
            end
            PUSH: begin
                mem_we   = 1'b1;
                depth_d  = depth_q + DEPTH_W'(1);
                is_pop_d = 1'b0;
                state_d  = LOAD;
            end
            POP: begin
                mem_re   = 1'b1;
                depth_d  = depth_q - DEPTH_W'(1);
                is_pop_d = 1'b1;
                state_d  = LOAD;
            end
            default: begin
                pc_load_d = 1'b1;
                pc_addr_d = is_pop_q ? mem_rdata[ENTRY_W-1 -: ADDR_W] : vec_q;
`ifdef INT_CTX_FLAG_SAVE_EN
                flag_load_d = is_pop_q;
                if (is_pop_q) flag_d = mem_rdata[FLAG_W-1:0];
`endif
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            int_prev_q  <= 1'b0;
            rec_prev_q  <= 1'b0;
            int_pend_q  <= 1'b0;
            rec_pend_q  <= 1'b0;
            pend_vec_q  <= '0;
            vec_q       <= '0;
            depth_q     <= '0;
            is_pop_q    <= 1'b0;
            busy_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            flag_load_q <= 1'b0;
            pc_addr_q   <= '0;
            flag_q      <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_prev_q  <= bus.i_interrupt_enable;
            rec_prev_q  <= bus.i_recovery_enable;
            int_pend_q  <= int_pend_d;
            rec_pend_q  <= rec_pend_d;
            pend_vec_q  <= pend_vec_d;
            vec_q       <= vec_d;
            depth_q     <= depth_d;
            is_pop_q    <= is_pop_d;
            busy_q      <= busy_d;
            pc_load_q   <= pc_load_d;
            flag_load_q <= flag_load_d;
            pc_addr_q   <= pc_addr_d;
            flag_q      <= flag_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    ctx_lifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (IDX_W'(depth_q)),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (IDX_W'(depth_q - DEPTH_W'(1))),
        .rdata_o (mem_rdata)
    );

    assign bus.o_pc_load    = pc_load_q;
    assign bus.o_pc_address = pc_addr_q;
    assign bus.o_flag_load  = flag_load_q;
    assign bus.o_flag       = flag_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_depth      = depth_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_underflow  = unf_q;

endmodule

// File: tb/tb_interrupt_context_stack.sv
// Self-checking bench: directed scenarios plus random entry/exit traffic against a queue model.
module tb_interrupt_context_stack;

    localparam int ADDR_W = 16;
    localparam int FLAG_W = 16;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [FLAG_W-1:0] flag;
    } ctx_t;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    interrupt_context_stack_if #(.ADDR_W(ADDR_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) ifc ();

    interrupt_context_stack #(.ADDR_W(ADDR_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifc.slave)
    );

    ctx_t stack[$];
    bit   exp_ovf, exp_unf;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_load"},   32'(ifc.o_pc_load),    0);
        check({tag, "_pc_addr"},   32'(ifc.o_pc_address), 0);
        check({tag, "_flag_load"}, 32'(ifc.o_flag_load),  0);
        check({tag, "_flag"},      32'(ifc.o_flag),       0);
        check({tag, "_busy"},      32'(ifc.o_busy),       0);
        check({tag, "_depth"},     32'(ifc.o_depth),      0);
        check({tag, "_ovf"},       32'(ifc.o_overflow),   0);
        check({tag, "_unf"},       32'(ifc.o_underflow),  0);
    endtask

    // One request pulse and its full response window, predicted from the LIFO model.
    task automatic do_op(input bit entry, input logic [ADDR_W-1:0] vec);
        bit                accept;
        logic [ADDR_W-1:0] exp_addr;
        ctx_t              e;
        accept = entry ? (stack.size() < DEPTH) : (stack.size() > 0);
        if (entry) begin
            ifc.i_interrupt_address = vec;
            ifc.i_interrupt_enable  = 1'b1;
        end else begin
            ifc.i_recovery_enable = 1'b1;
        end
        tick();
        ifc.i_interrupt_enable = 1'b0;
        ifc.i_recovery_enable  = 1'b0;
        if (!accept) begin
            if (entry) exp_ovf = 1'b1;
            else       exp_unf = 1'b1;
            check("refuse_ovf",  32'(ifc.o_overflow),  32'(exp_ovf));
            check("refuse_unf",  32'(ifc.o_underflow), 32'(exp_unf));
            check("refuse_busy", 32'(ifc.o_busy),      0);
            repeat (2) begin
                tick();
                check("refuse_no_load", 32'(ifc.o_pc_load), 0);
            end
            check("refuse_depth", 32'(ifc.o_depth), 32'(stack.size()));
        end else begin
            check("busy_after_edge", 32'(ifc.o_busy), 1);
            if (entry) begin
                e.pc   = ifc.i_pc;
                e.flag = ifc.i_flag;
                stack.push_back(e);
                exp_addr = vec;
            end else begin
                e = stack.pop_back();
                exp_addr = e.pc;
            end
            tick();
            check("load_early", 32'(ifc.o_pc_load), 0);
            check("busy_mid",   32'(ifc.o_busy),    1);
            tick();
            check("pc_load",  32'(ifc.o_pc_load),    1);
            check("pc_addr",  32'(ifc.o_pc_address), 32'(exp_addr));
            check("depth",    32'(ifc.o_depth),      32'(stack.size()));
            check("busy_end", 32'(ifc.o_busy),       0);
`ifdef INT_CTX_FLAG_SAVE_EN
            check("flag_load", 32'(ifc.o_flag_load), 32'(!entry));
            if (!entry) check("flag", 32'(ifc.o_flag), 32'(e.flag));
`else
            check("flag_load", 32'(ifc.o_flag_load), 0);
            check("flag",      32'(ifc.o_flag),      0);
`endif
            tick();
            check("pc_load_one_cycle", 32'(ifc.o_pc_load),   0);
            check("flag_load_off",     32'(ifc.o_flag_load), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0;
        ifc.i_interrupt_enable  = 1'b0;
        ifc.i_interrupt_address = '0;
        ifc.i_recovery_enable   = 1'b0;
        ifc.i_pc   = '0;
        ifc.i_flag = '0;
        repeat (2) tick();
        check_all_zero("reset");
        n_rst = 1'b1;
        tick();

        // Basic entry then exit.
        ifc.i_pc   = 16'h1234;
        ifc.i_flag = 16'h00A5;
        do_op(1'b1, 16'hFDA9);
        ifc.i_pc   = 16'hFDA9;
        ifc.i_flag = 16'h0000;
        do_op(1'b0, 16'h0000);

        // Recovery with nothing saved.
        do_op(1'b0, 16'h0000);

        // Fill to DEPTH, one refused entry, then drain in reverse order.
        for (int i = 0; i <= DEPTH; i++) begin
            ifc.i_pc   = 16'(16'h1000 + i);
            ifc.i_flag = 16'(16'h0A00 + i);
            do_op(1'b1, 16'(16'h8000 + i));
        end
        for (int i = 0; i < DEPTH; i++) do_op(1'b0, 16'h0000);

        // Simultaneous edges at depth 1: entry first, then the latched recovery.
        ifc.i_pc = 16'h4444;
        do_op(1'b1, 16'h0C0C);
        ifc.i_pc   = 16'h5555;
        ifc.i_flag = 16'h0033;
        ifc.i_interrupt_address = 16'h0BAD;
        ifc.i_interrupt_enable  = 1'b1;
        ifc.i_recovery_enable   = 1'b1;
        tick();
        ifc.i_interrupt_enable = 1'b0;
        ifc.i_recovery_enable  = 1'b0;
        check("sim_busy", 32'(ifc.o_busy), 1);
        repeat (2) tick();
        check("sim_entry_load",  32'(ifc.o_pc_load),    1);
        check("sim_entry_addr",  32'(ifc.o_pc_address), 32'h0BAD);
        check("sim_entry_depth", 32'(ifc.o_depth),      2);
        tick();
        check("sim_pop_started", 32'(ifc.o_busy),    1);
        check("sim_gap",         32'(ifc.o_pc_load), 0);
        repeat (2) tick();
        check("sim_exit_load",  32'(ifc.o_pc_load),    1);
        check("sim_exit_addr",  32'(ifc.o_pc_address), 32'h5555);
        check("sim_exit_depth", 32'(ifc.o_depth),      1);
`ifdef INT_CTX_FLAG_SAVE_EN
        check("sim_exit_flag", 32'(ifc.o_flag), 32'h0033);
`endif
        tick();
        check("sim_exit_one_cycle", 32'(ifc.o_pc_load), 0);

        // Reset while in PUSH discards everything and suppresses the load.
        ifc.i_interrupt_address = 16'h7777;
        ifc.i_interrupt_enable  = 1'b1;
        tick();
        ifc.i_interrupt_enable = 1'b0;
        n_rst = 1'b0;
        tick();
        check_all_zero("midreset");
        n_rst = 1'b1;
        stack.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        repeat (3) begin
            tick();
            check("midreset_no_load", 32'(ifc.o_pc_load), 0);
            check("midreset_depth",   32'(ifc.o_depth),   0);
        end

        // Random traffic, biased toward entries so the stack reaches both limits.
        for (int i = 0; i < 80; i++) begin
            ifc.i_pc   = 16'($urandom);
            ifc.i_flag = 16'($urandom);
            do_op(($urandom_range(0, 9) < 6), 16'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_context_stack.md
# interrupt_context_stack

Sits directly downstream of the interrupt/control block. It consumes that block's interrupt-enable pulse/level, interrupt vector and recovery-enable signals. On interrupt entry it saves the current program counter (and optionally the flag word) on a hardware LIFO, then drives the vector into the program counter. On recovery it pops the saved context and reloads the program counter and flags.

## Interface
Parameters:
- ADDR_W, 16, width of program-counter and vector addresses
- FLAG_W, 16, width of the saved flag word
- DEPTH, 8, maximum interrupt nesting depth (power of two, ≥2)

Ports:
- clk  input  1  system clock; one clock, all logic on rising edge
- n_rst  input  1  reset, synchronous, active-low
- i_interrupt_enable  input  1  interrupt request (pulse or level) from the controller
- i_interrupt_address  input  ADDR_W  vector, valid while i_interrupt_enable high
- i_recovery_enable  input  1  return-from-interrupt request (pulse or level)
- i_pc  input  ADDR_W  current program-counter value
- i_flag  input  FLAG_W  current flag word
- o_pc_load  output  1  one-cycle strobe: program counter loads o_pc_address
- o_pc_address  output  ADDR_W  vector on entry, saved PC on exit
- o_flag_load  output  1  one-cycle strobe: flag register loads o_flag (exit only)
- o_flag  output  FLAG_W  restored flag word
- o_busy  output  1  state ≠ IDLE
- o_depth  output  $clog2(DEPTH+1)  current nesting depth
- o_overflow  output  1  sticky: entry refused because the stack was full
- o_underflow  output  1  sticky: recovery refused because the stack was empty

## Operation
- Rising-edge detect on both requests using registered previous samples. Previous samples reset to 0, so a request already high when reset releases counts as an edge.
- FSM states: IDLE, PUSH, POP, LOAD.
- IDLE, interrupt edge:
  - depth < DEPTH: capture vector, go to PUSH.
  - depth == DEPTH: set o_overflow, stay IDLE, no load.
- IDLE, recovery edge:
  - depth > 0: go to POP.
  - depth == 0: set o_underflow, stay IDLE, no load.
- Both edges in the same cycle: entry is serviced first. The recovery edge is latched as pending and serviced on return to IDLE.
- PUSH: write {i_pc, i_flag} at index depth, then depth+1. Go to LOAD with o_pc_address = captured vector.
- POP: depth−1, then registered read of entry [depth−1]. Go to LOAD with o_pc_address = saved PC and o_flag = saved flags.
- LOAD: assert o_pc_load for one cycle; on exit also assert o_flag_load. Then return to IDLE.
- Edges arriving while busy latch into a one-deep pending bit per request. A second edge of the same kind while its bit is already set is dropped; no error is raised.
- Pending entry has priority over pending recovery when servicing from IDLE.
- Sticky error flags clear only on reset.
- Depth arithmetic never wraps. Full and empty are checked before every push and pop.

## Timing
- Reset (n_rst low at a clock edge): state IDLE, depth 0, pending bits 0. All outputs 0: o_pc_load, o_pc_address, o_flag_load, o_flag, o_busy, o_depth, o_overflow, o_underflow.
- Reset mid-operation aborts the operation: no load strobe is issued and stack contents are discarded.
- Latency: edge detected at clock N; o_busy high after N; o_pc_load high during the cycle after edge N+2, for exactly one cycle. The same latency applies to entry and exit.
- i_pc and i_flag are sampled at edge N+1 (the PUSH cycle). The program counter must hold its value while o_busy is high.
- Minimum spacing between back-to-back serviced operations: 3 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- INT_CTX_FLAG_SAVE_EN defined:
  - Stack entries are ADDR_W+FLAG_W wide.
  - Flags are saved on entry and restored on exit with o_flag_load.
- INT_CTX_FLAG_SAVE_EN not defined:
  - Stack entries are ADDR_W only.
  - i_flag is ignored.
  - o_flag_load and o_flag are tied to 0.

## Structure
- Shared package macpu_int_pkg holds:
  - FSM state enum (IDLE/PUSH/POP/LOAD)
  - default DEPTH
  - the context-entry struct, with the flag field present under INT_CTX_FLAG_SAVE_EN
- One sub-module, ctx_lifo_mem: DEPTH-entry register file with synchronous write and registered read, indexed by the FSM. Occupancy tracking stays in the parent.

## Test plan
- Entry: i_pc=0x1234, i_flag=0x00A5, one-cycle i_interrupt_enable with vector 0xFDA9 → o_pc_load for one cycle with o_pc_address=0xFDA9 two edges after detection; o_depth=1.
- Exit: after entry, pulse i_recovery_enable → o_pc_address=0x1234, o_flag=0x00A5 (flag strobe only with INT_CTX_FLAG_SAVE_EN); o_depth=0.
- Nesting to full: DEPTH+1 entries with distinct PCs → ninth entry sets o_overflow with no load; DEPTH recoveries return the PCs in reverse order.
- Underflow: recovery with depth 0 → o_underflow=1, no o_pc_load, o_depth stays 0.
- Simultaneous and busy: interrupt and recovery edges in the same cycle at depth 1 → entry completes (depth 2), then the pending recovery pops it (depth 1, PC restored).
- Reset mid-PUSH: n_rst low for one edge → all outputs 0, o_depth=0, no o_pc_load afterwards.
